// File: rtl/demux2_stream.sv
// 1-to-2 stream demultiplexer: each accepted word is steered by in_sel into one
// of two independent FIFOs, so a stalled consumer never blocks the other output.
module demux2_stream #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [LW-1:0]    level0,
    output logic [LW-1:0]    level1
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [WIDTH-1:0] mem [2][DEPTH];
    logic [PW-1:0]    wr_ptr [2];
    logic [PW-1:0]    rd_ptr [2];
    logic [LW-1:0]    level  [2];
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       out_ready_vec;

    // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
    // in_ready looks only at the selected FIFO's level, never at a consumer's ready.
    assign in_ready      = rst_n & (level[in_sel] != FULL_LEVEL);
    assign out_ready_vec = {out1_ready, out0_ready};

    always_comb begin
        push = '0;
        pop  = '0;
        push[0] = in_valid & in_ready & ~in_sel;
        push[1] = in_valid & in_ready & in_sel;
        for (int k = 0; k < 2; k++) begin
            pop[k] = (level[k] != '0) & out_ready_vec[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                level[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (push[k]) wr_ptr[k] <= wr_ptr[k] + PW'(1);
                if (pop[k])  rd_ptr[k] <= rd_ptr[k] + PW'(1);
                // Full/empty come from the level; pointers alone are ambiguous.
                case ({push[k], pop[k]})
                    2'b10:   level[k] <= level[k] + LW'(1);
                    2'b01:   level[k] <= level[k] - LW'(1);
                    default: level[k] <= level[k];
                endcase
            end
        end
    end

    // Storage is deliberately not reset; data is only observed while valid.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (push[k]) mem[k][wr_ptr[k]] <= in_data;
        end
    end

    assign out0_data  = mem[0][rd_ptr[0]];
    assign out1_data  = mem[1][rd_ptr[1]];
    assign out0_valid = (level[0] != '0);
    assign out1_valid = (level[1] != '0);
    assign level0     = level[0];
    assign level1     = level[1];

endmodule

// File: tb/tb_demux2_stream.sv
// Scoreboard bench for demux2_stream: directed scenarios followed by random stress,
// checked against per-output queues of accepted words.
module tb_demux2_stream;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [LW-1:0]    level0;
    logic [LW-1:0]    level1;

    logic [WIDTH-1:0] exp_q0[$];
    logic [WIDTH-1:0] exp_q1[$];
    int checks = 0;
    int errors = 0;

    demux2_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
        .level0(level0), .level1(level1)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    // Model: each output is a bounded queue; level = queue size, valid = non-empty,
    // accept when the selected queue is below DEPTH.
    always @(negedge clk) begin
        int sz0, sz1;
        logic model_ready;
        if (!rst_n) begin
            check("rst_out0_valid", 32'(out0_valid), 32'd0);
            check("rst_out1_valid", 32'(out1_valid), 32'd0);
            check("rst_level0", 32'(level0), 32'd0);
            check("rst_level1", 32'(level1), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd0);
        end else begin
            sz0 = exp_q0.size();
            sz1 = exp_q1.size();
            model_ready = ((in_sel ? sz1 : sz0) < DEPTH);
            check("level0", 32'(level0), 32'(sz0));
            check("level1", 32'(level1), 32'(sz1));
            check("level0_bound", 32'(level0 <= LW'(DEPTH)), 32'd1);
            check("level1_bound", 32'(level1 <= LW'(DEPTH)), 32'd1);
            check("out0_valid", 32'(out0_valid), 32'(sz0 != 0));
            check("out1_valid", 32'(out1_valid), 32'(sz1 != 0));
            check("in_ready", 32'(in_ready), 32'(model_ready));
            if (sz0 != 0 && out0_ready) check("out0_data", out0_data, exp_q0.pop_front());
            if (sz1 != 0 && out1_ready) check("out1_data", out1_data, exp_q1.pop_front());
            if (in_valid && model_ready) begin
                if (in_sel) exp_q1.push_back(in_data);
                else        exp_q0.push_back(in_data);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic wait_accept(input string name, output int cycles);
        logic acc;
        cycles = 0;
        acc = 1'b0;
        while (!acc && cycles < 50) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!acc) check({name, "_timeout"}, 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic s, output int cycles);
        in_data  = d;
        in_sel   = s;
        in_valid = 1'b1;
        wait_accept("send", cycles);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        rst_n      = 1'b0;
        in_data    = '0;
        in_sel     = 1'b0;
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // Routing by sel with both consumers ready.
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        send(32'hA1, 1'b0, cyc);
        send(32'hB2, 1'b1, cyc);
        idle(3);
        @(negedge clk);
        check("route_level0_zero", 32'(level0), 32'd0);
        check("route_level1_zero", 32'(level1), 32'd0);
        @(posedge clk); #1;

        // Fill FIFO 0 and observe backpressure on the third word.
        out0_ready = 1'b0;
        send(32'h1, 1'b0, cyc);
        send(32'h2, 1'b0, cyc);
        in_data  = 32'h3;
        in_sel   = 1'b0;
        in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("full_in_ready", 32'(in_ready), 32'd0);
            check("full_level0", 32'(level0), 32'd2);
            @(posedge clk); #1;
        end
        out0_ready = 1'b1;
        wait_accept("word3", cyc);
        idle(4);

        // Head-of-line independence: FIFO 0 full and stalled, sel=1 goes through.
        out0_ready = 1'b0;
        send(32'h10, 1'b0, cyc);
        send(32'h11, 1'b0, cyc);
        out1_ready = 1'b1;
        send(32'h55, 1'b1, cyc);
        check("hol_accept_cycles", 32'(cyc), 32'd1);
        @(negedge clk);
        check("hol_level0", 32'(level0), 32'd2);
        @(posedge clk); #1;
        idle(2);

        // Steady push+pop on FIFO 1 at level 1 across several pointer wraps.
        out1_ready = 1'b0;
        send(32'h100, 1'b1, cyc);
        out1_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data  = 32'h200 + 32'(i);
            in_sel   = 1'b1;
            in_valid = 1'b1;
            @(negedge clk);
            check("stream_level1", 32'(level1), 32'd1);
            check("stream_in_ready", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        idle(2);

        // Reset mid-stream with level0=2, level1=1.
        out1_ready = 1'b0;
        send(32'h77, 1'b1, cyc);
        @(negedge clk);
        check("pre_rst_level0", 32'(level0), 32'd2);
        check("pre_rst_level1", 32'(level1), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        #1;
        check("async_rst_out0_valid", 32'(out0_valid), 32'd0);
        check("async_rst_out1_valid", 32'(out1_valid), 32'd0);
        check("async_rst_level0", 32'(level0), 32'd0);
        check("async_rst_level1", 32'(level1), 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        send(32'hAA, 1'b0, cyc);
        idle(3);

        // Random stress; in_data/in_sel hold while a word is pending.
        begin
            logic acc;
            acc = 1'b0;
            for (int i = 0; i < 10000; i++) begin
                if (!in_valid || acc) begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    in_data  = $urandom;
                    in_sel   = 1'($urandom_range(0, 1));
                end
                out0_ready = ($urandom_range(0, 2) != 0);
                out1_ready = ($urandom_range(0, 3) == 0);
                @(negedge clk);
                acc = in_valid && in_ready;
                @(posedge clk); #1;
            end
        end
        in_valid   = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        idle(DEPTH + 3);
        @(negedge clk);
        check("drain_level0", 32'(level0), 32'd0);
        check("drain_level1", 32'(level1), 32'd0);
        check("drain_out0_valid", 32'(out0_valid), 32'd0);
        check("drain_out1_valid", 32'(out1_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
